// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer for the OoO backend.
// Ports: clk/rst (sync, active-high); disp_* allocate up to DISP_W entries
//   per cycle, disp_ready/disp_idx report space and assigned slots;
//   wb_* complete entries (optionally faulting); flush_* squash entries
//   younger than flush_idx; ret_* retire up to RET_W oldest done entries;
//   exc_valid/exc_idx pulse when a faulting entry reaches the head;
//   count/empty report occupancy.
module reorder_buffer #(
    parameter int ENTRIES  = 32,
    parameter int DISP_W   = 2,
    parameter int RET_W    = 2,
    parameter int WB_PORTS = 3,
    parameter int DATA_W   = 32,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 6,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W-1:0]          disp_has_dst,
    input  logic [DISP_W*AREG_W-1:0]   disp_areg,
    input  logic [DISP_W*PREG_W-1:0]   disp_preg,
    output logic                       disp_ready,
    output logic [DISP_W*IDX_W-1:0]    disp_idx,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]  wb_idx,
    input  logic [WB_PORTS*DATA_W-1:0] wb_data,
    input  logic [WB_PORTS-1:0]        wb_exc,
    input  logic                       flush_valid,
    input  logic [IDX_W-1:0]           flush_idx,
    output logic [RET_W-1:0]           ret_valid,
    output logic [RET_W-1:0]           ret_has_dst,
    output logic [RET_W*AREG_W-1:0]    ret_areg,
    output logic [RET_W*PREG_W-1:0]    ret_preg,
    output logic [RET_W*DATA_W-1:0]    ret_data,
    output logic                       exc_valid,
    output logic [IDX_W-1:0]           exc_idx,
    output logic [IDX_W:0]             count,
    output logic                       empty
);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cnt_t;

    idx_t head, tail;
    cnt_t cnt;

    logic [ENTRIES-1:0] e_valid, e_done, e_exc, e_has_dst;
    logic [AREG_W-1:0]  e_areg [ENTRIES];
    logic [PREG_W-1:0]  e_preg [ENTRIES];
    logic [DATA_W-1:0]  e_data [ENTRIES];

    logic               exc_now, disp_go;
    cnt_t               n_ret, n_disp, cnt_nxt;
    idx_t               fdist;
    logic [ENTRIES-1:0] squash, v_nxt, d_nxt, x_nxt;

    function automatic idx_t ptr(input idx_t base, input int off);
        return base + idx_t'(off);
    endfunction

    function automatic idx_t wbi(input int p);
        return wb_idx[p*IDX_W +: IDX_W];
    endfunction

    assign exc_now    = e_valid[head] & e_done[head] & e_exc[head];
    assign exc_valid  = exc_now;
    assign exc_idx    = head;
    assign disp_ready = cnt <= cnt_t'(ENTRIES - DISP_W);
    assign disp_go    = disp_ready & ~flush_valid & ~exc_now;
    assign count      = cnt;
    assign empty      = (cnt == '0);
    assign fdist      = flush_idx - head;

    always_comb begin : disp_lanes
        disp_idx = '0;
        n_disp   = '0;
        for (int i = 0; i < DISP_W; i++) begin
            disp_idx[i*IDX_W +: IDX_W] = ptr(tail, i);
            if (disp_go && disp_valid[i])
                n_disp = n_disp + cnt_t'(1);
        end
    end

    // Eligibility chains: a lane retires only if every older lane does.
    always_comb begin : retire
        logic ok;
        idx_t r;
        ok          = 1'b1;
        r           = head;
        n_ret       = '0;
        ret_valid   = '0;
        ret_has_dst = '0;
        ret_areg    = '0;
        ret_preg    = '0;
        ret_data    = '0;
        for (int k = 0; k < RET_W; k++) begin
            r  = ptr(head, k);
            ok = ok & e_valid[r] & e_done[r] & ~e_exc[r];
            ret_valid[k]   = ok;
            ret_has_dst[k] = e_has_dst[r];
            ret_areg[k*AREG_W +: AREG_W] = e_areg[r];
            ret_preg[k*PREG_W +: PREG_W] = e_preg[r];
            ret_data[k*DATA_W +: DATA_W] = e_data[r];
            if (ok)
                n_ret = n_ret + cnt_t'(1);
        end
    end

    // Squash by age: distance from head beyond that of flush_idx.
    always_comb begin : squash_mask
        idx_t d;
        d      = '0;
        squash = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            d         = idx_t'(j) - head;
            squash[j] = flush_valid && (d > fdist);
        end
    end

    always_comb begin : next_flags
        idx_t a;
        a     = '0;
        v_nxt = e_valid;
        d_nxt = e_done;
        x_nxt = e_exc;
        for (int p = 0; p < WB_PORTS; p++) begin
            a = wbi(p);
            if (wb_valid[p] && e_valid[a]) begin
                d_nxt[a] = 1'b1;
                x_nxt[a] = wb_exc[p];
            end
        end
        for (int k = 0; k < RET_W; k++) begin
            a = ptr(head, k);
            if (ret_valid[k])
                v_nxt[a] = 1'b0;
        end
        v_nxt = v_nxt & ~squash;
        for (int i = 0; i < DISP_W; i++) begin
            a = ptr(tail, i);
            if (disp_go && disp_valid[i]) begin
                v_nxt[a] = 1'b1;
                d_nxt[a] = 1'b0;
                x_nxt[a] = 1'b0;
            end
        end
    end

    // After a partial flush the survivors run head..flush_idx inclusive.
    assign cnt_nxt = flush_valid
                   ? cnt_t'(fdist) + cnt_t'(1) - n_ret
                   : cnt + n_disp - n_ret;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            e_valid <= '0;
            e_done  <= '0;
            e_exc   <= '0;
        end else if (exc_now) begin
            tail    <= head;
            cnt     <= '0;
            e_valid <= '0;
        end else begin
            head    <= head + n_ret[IDX_W-1:0];
            tail    <= flush_valid ? flush_idx + idx_t'(1)
                                   : tail + n_disp[IDX_W-1:0];
            cnt     <= cnt_nxt;
            e_valid <= v_nxt;
            e_done  <= d_nxt;
            e_exc   <= x_nxt;
        end
    end

    // Payload needs no reset: it is only observed behind e_valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && e_valid[wbi(p)])
                e_data[wbi(p)] <= wb_data[p*DATA_W +: DATA_W];
        end
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_go && disp_valid[i]) begin
                e_has_dst[ptr(tail, i)] <= disp_has_dst[i];
                e_areg[ptr(tail, i)] <= disp_areg[i*AREG_W +: AREG_W];
                e_preg[ptr(tail, i)] <= disp_preg[i*PREG_W +: PREG_W];
            end
        end
    end

    a_disp_contig: assert property (@(posedge clk) disable iff (rst)
        ((disp_valid & (disp_valid + DISP_W'(1))) == '0));

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized + directed bench for reorder_buffer,
// checked every cycle against a queue-based model of the ROB contents.
module tb_reorder_buffer;

    localparam int E  = 32;
    localparam int DW = 2;
    localparam int RW = 2;
    localparam int WP = 3;
    localparam int DA = 32;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int IW = 5;

    logic             clk, rst;
    logic [DW-1:0]    disp_valid, disp_has_dst;
    logic [DW*AW-1:0] disp_areg;
    logic [DW*PW-1:0] disp_preg;
    logic             disp_ready;
    logic [DW*IW-1:0] disp_idx;
    logic [WP-1:0]    wb_valid, wb_exc;
    logic [WP*IW-1:0] wb_idx;
    logic [WP*DA-1:0] wb_data;
    logic             flush_valid;
    logic [IW-1:0]    flush_idx;
    logic [RW-1:0]    ret_valid, ret_has_dst;
    logic [RW*AW-1:0] ret_areg;
    logic [RW*PW-1:0] ret_preg;
    logic [RW*DA-1:0] ret_data;
    logic             exc_valid;
    logic [IW-1:0]    exc_idx;
    logic [IW:0]      count;
    logic             empty;

    reorder_buffer #(
        .ENTRIES(E), .DISP_W(DW), .RET_W(RW), .WB_PORTS(WP),
        .DATA_W(DA), .AREG_W(AW), .PREG_W(PW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_has_dst(disp_has_dst),
        .disp_areg(disp_areg), .disp_preg(disp_preg),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx),
        .wb_data(wb_data), .wb_exc(wb_exc),
        .flush_valid(flush_valid), .flush_idx(flush_idx),
        .ret_valid(ret_valid), .ret_has_dst(ret_has_dst),
        .ret_areg(ret_areg), .ret_preg(ret_preg),
        .ret_data(ret_data), .exc_valid(exc_valid),
        .exc_idx(exc_idx), .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] areg;
        logic [PW-1:0] preg;
        bit            has_dst;
        bit            done;
        bit            exc;
        logic [DA-1:0] data;
    } ent_t;

    ent_t rob[$];
    int   m_head;
    bit   chk_en;
    int   n_vec, n_err;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int m_nret();
        int k = 0;
        while (k < RW && k < rob.size() && rob[k].done && !rob[k].exc)
            k++;
        return k;
    endfunction

    function automatic bit m_exc();
        return rob.size() > 0 && rob[0].done && rob[0].exc;
    endfunction

    function automatic int m_pos(input int idx);
        return (idx - m_head + E) % E;
    endfunction

    // Model advance at the clock edge, from pre-edge model state.
    task automatic m_step();
        int nr, sz, pos, keep;
        bit rdy;
        ent_t e;
        if (rst) begin
            rob.delete();
            m_head = 0;
        end else if (m_exc()) begin
            rob.delete();
        end else begin
            nr  = m_nret();
            sz  = rob.size();
            rdy = (E - sz) >= DW;
            for (int p = 0; p < WP; p++) begin
                if (wb_valid[p]) begin
                    pos = m_pos(int'(wb_idx[p*IW +: IW]));
                    if (pos < sz) begin
                        e = rob[pos];
                        e.done = 1'b1;
                        e.exc  = wb_exc[p];
                        e.data = wb_data[p*DA +: DA];
                        rob[pos] = e;
                    end
                end
            end
            if (flush_valid) begin
                keep = m_pos(int'(flush_idx)) + 1;
                while (rob.size() > keep)
                    void'(rob.pop_back());
            end
            for (int k = 0; k < nr; k++)
                void'(rob.pop_front());
            m_head = (m_head + nr) % E;
            if (rdy && !flush_valid) begin
                for (int i = 0; i < DW; i++) begin
                    if (disp_valid[i]) begin
                        e.areg    = disp_areg[i*AW +: AW];
                        e.preg    = disp_preg[i*PW +: PW];
                        e.has_dst = disp_has_dst[i];
                        e.done    = 1'b0;
                        e.exc     = 1'b0;
                        e.data    = '0;
                        rob.push_back(e);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        int nr;
        if (chk_en) begin
            nr = m_nret();
            chk("count", count, rob.size());
            chk("empty", empty, rob.size() == 0);
            chk("disp_ready", disp_ready, (E - rob.size()) >= DW);
            for (int i = 0; i < DW; i++)
                chk("disp_idx", disp_idx[i*IW +: IW],
                    (m_head + rob.size() + i) % E);
            chk("exc_valid", exc_valid, m_exc());
            if (m_exc())
                chk("exc_idx", exc_idx, m_head);
            for (int k = 0; k < RW; k++) begin
                chk("ret_valid", ret_valid[k], k < nr);
                if (k < nr) begin
                    chk("ret_has_dst", ret_has_dst[k], rob[k].has_dst);
                    chk("ret_areg", ret_areg[k*AW +: AW], rob[k].areg);
                    chk("ret_preg", ret_preg[k*PW +: PW], rob[k].preg);
                    chk("ret_data", ret_data[k*DA +: DA], rob[k].data);
                end
            end
        end
    end

    task automatic idle();
        disp_valid   = '0;
        disp_has_dst = '0;
        disp_areg    = '0;
        disp_preg    = '0;
        wb_valid     = '0;
        wb_idx       = '0;
        wb_data      = '0;
        wb_exc       = '0;
        flush_valid  = 1'b0;
        flush_idx    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    // Lane i gets areg = base+i, preg = base+i+32 (mod width).
    task automatic disp(input int n, input int base);
        for (int i = 0; i < DW; i++) begin
            disp_valid[i]   = (i < n);
            disp_has_dst[i] = 1'b1;
            disp_areg[i*AW +: AW] = AW'(base + i);
            disp_preg[i*PW +: PW] = PW'(base + i + 32);
        end
    endtask

    task automatic wb(input int p, input int idx,
                      input logic [DA-1:0] d, input bit x);
        wb_valid[p]          = 1'b1;
        wb_idx[p*IW +: IW]   = IW'(idx);
        wb_data[p*DA +: DA]  = d;
        wb_exc[p]            = x;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Complete oldest pending entries until the ROB empties.
    task automatic drain();
        int g, p;
        g = 0;
        while (rob.size() > 0 && g < 200) begin
            idle();
            p = 0;
            for (int j = 0; j < rob.size() && p < WP; j++) begin
                if (!rob[j].done) begin
                    wb(p, (m_head + j) % E, $urandom, 1'b0);
                    p++;
                end
            end
            tick();
            g++;
        end
        idle();
        chk("drain_count", count, 0);
    endtask

    task automatic rand_stim(input int wbp);
        int cand[$];
        int nr, lo, j, sz, dn;
        idle();
        rst = ($urandom_range(0, 499) == 0);
        dn = $urandom_range(0, 2);
        for (int i = 0; i < DW; i++) begin
            disp_valid[i]   = (i < dn);
            disp_has_dst[i] = $urandom_range(0, 1);
            disp_areg[i*AW +: AW] = AW'($urandom);
            disp_preg[i*PW +: PW] = PW'($urandom);
        end
        sz = rob.size();
        for (int k = 0; k < sz; k++)
            if (!rob[k].done) cand.push_back(k);
        for (int p = 0; p < WP; p++) begin
            if (cand.size() > 0 && $urandom_range(0, 99) < wbp) begin
                j = $urandom_range(0, cand.size() - 1);
                wb(p, (m_head + cand[j]) % E, $urandom,
                   $urandom_range(0, 59) == 0);
                cand.delete(j);
            end else if (sz < E && $urandom_range(0, 29) == 0) begin
                wb(p, (m_head + sz + $urandom_range(0, E - sz - 1)) % E,
                   $urandom, 1'b0);
            end
        end
        if (sz > 0 && $urandom_range(0, 24) == 0) begin
            nr = m_nret();
            lo = (nr > 0) ? nr - 1 : 0;
            flush_valid = 1'b1;
            flush_idx   = IW'((m_head + $urandom_range(lo, sz - 1)) % E);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [DA-1:0] d0, d1;
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        m_head = 0;
        idle();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", disp_ready, 1);
        chk("rst_idx0", disp_idx[IW-1:0], 0);
        chk("rst_idx1", disp_idx[2*IW-1:IW], 1);
        chk("rst_ret", ret_valid, 0);
        chk("rst_exc", exc_valid, 0);

        // Fill to 32 entries, two per cycle.
        for (int c = 0; c < 16; c++) begin
            chk("fill_idx0", disp_idx[IW-1:0], 2 * c);
            chk("fill_idx1", disp_idx[2*IW-1:IW], 2 * c + 1);
            if (c == 15) chk("ready_at30", disp_ready, 1);
            disp(2, 2 * c);
            tick();
        end
        idle();
        chk("full_count", count, 32);
        chk("full_ready", disp_ready, 0);

        // Complete 1 then 0 in one cycle on separate ports.
        d0 = $urandom;
        d1 = $urandom;
        wb(0, 1, d1, 1'b0);
        wb(1, 0, d0, 1'b0);
        tick();
        idle();
        chk("ret2_valid", ret_valid, 2'b11);
        chk("ret2_d0", ret_data[DA-1:0], d0);
        chk("ret2_d1", ret_data[2*DA-1:DA], d1);
        chk("ret2_areg0", ret_areg[AW-1:0], 0);
        chk("ret2_preg1", ret_preg[2*PW-1:PW], 33);
        tick();
        chk("head2_count", count, 30);
        chk("head2_ret", ret_valid, 0);
        drain();

        // Wrap: tail at 31 after partial retirement.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            disp(2, 2 * c);
            tick();
        end
        disp(1, 30);
        tick();
        idle();
        chk("wrap_tail31", count, 31);
        chk("wrap_ready0", disp_ready, 0);
        wb(0, 0, $urandom, 1'b0);
        wb(1, 1, $urandom, 1'b0);
        wb(2, 2, $urandom, 1'b0);
        tick();
        idle();
        tick();
        chk("wrap_idx0", disp_idx[IW-1:0], 31);
        chk("wrap_idx1", disp_idx[2*IW-1:IW], 0);
        disp(2, 7);
        tick();
        idle();
        drain();

        // Partial flush keeps 0..4.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            disp(2, 2 * c);
            tick();
        end
        idle();
        flush_valid = 1'b1;
        flush_idx   = 4;
        tick();
        idle();
        chk("flush_count", count, 5);
        chk("flush_next_idx", disp_idx[IW-1:0], 5);
        wb(0, 7, $urandom, 1'b0);
        tick();
        idle();
        chk("squash_wb_count", count, 5);
        chk("squash_wb_ret", ret_valid, 0);
        disp(2, 20);
        tick();
        idle();
        chk("post_flush_count", count, 7);
        drain();

        // Faulting entry 2 behind two completed entries.
        do_reset();
        disp(2, 0);
        tick();
        disp(2, 2);
        tick();
        idle();
        wb(0, 0, $urandom, 1'b0);
        wb(1, 1, $urandom, 1'b0);
        wb(2, 2, $urandom, 1'b1);
        tick();
        idle();
        chk("exc_pre_ret", ret_valid, 2'b11);
        chk("exc_pre_valid", exc_valid, 0);
        tick();
        chk("exc_valid", exc_valid, 1);
        chk("exc_idx", exc_idx, 2);
        chk("exc_ret", ret_valid, 0);
        disp(2, 9);
        tick();
        idle();
        chk("exc_count", count, 0);
        chk("exc_empty", empty, 1);
        chk("exc_tail", disp_idx[IW-1:0], 2);

        // Reset with live entries and writebacks in flight.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            disp(2, 2 * c);
            tick();
        end
        idle();
        wb(0, 0, $urandom, 1'b0);
        wb(1, 3, $urandom, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ret", ret_valid, 0);
        chk("mid_rst_idx0", disp_idx[IW-1:0], 0);
        chk("mid_rst_idx1", disp_idx[2*IW-1:IW], 1);

        // Random traffic, alternating light and heavy completion.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rand_stim(((cyc / 400) % 2) ? 20 : 70);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
